ex_div_unit: RTL and testbench
==============================

# ex_div_unit

Iterative radix-2 restoring divider in the EX stage of the 5-stage RV32 pipeline. It executes DIV/DIVU/REM/REMU over multiple cycles. While busy, it drives a stall request into the hazard logic so the EX instruction and all older stages hold. It honours the EX flush that the hazard logic issues on a taken branch.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX instruction is a divide/remainder op (decoded, valid).
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- src1  input  WIDTH  dividend (forwarded rs1 value).
- src2  input  WIDTH  divisor (forwarded rs2 value).
- flush  input  1  EX flush from hazard logic (eFlush); aborts any operation.
- hold  input  1  downstream cannot accept EX result this cycle; freezes DONE.
- stall_req  output  1  freeze PC, IF/ID and ID/EX; clear EX/MEM bubble.
- result_valid  output  1  result is valid for EX/MEM capture this cycle.
- result  output  WIDTH  quotient or remainder per op.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE: on start && !flush, latch the operand magnitudes, the signs and the op, clear the partial remainder, set count=0, and go to CALC. Otherwise stay in IDLE.
  - CALC: each cycle, shift {rem,quo} left by 1 and trial-subtract the divisor magnitude. If the difference is non-negative, keep it and set the quotient LSB to 1. When count==WIDTH-1, go to DONE. Otherwise increment count.
  - DONE: apply the sign fix and present the result. If hold is high, stay in DONE. Otherwise return to IDLE.
  - flush, in any state, forces IDLE next cycle. It takes priority over start and hold.
- Signed ops (DIV/REM) operate on |src1| and |src2|.
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases must produce RISC-V results:
  - Divisor 0: quotient all-ones; remainder = src1.
  - DIV/REM of 0x80000000 by -1: quotient 0x80000000; remainder 0.
- Arithmetic widths:
  - The trial subtract is WIDTH+1 bits wide, so its borrow bit decides the step.
  - Magnitude of 0x80000000 is held as the unsigned 0x80000000. No overflow occurs in the magnitude path.
- stall_req = (IDLE && start && !flush) || CALC. It is deasserted in DONE, so the pipeline advances and captures the result.
- Outputs:
  - result_valid is high only in DONE.
  - result is don't-care when result_valid is low, but is driven to 0 to ease waveform checks.
- Reset values: state IDLE, count 0, stall_req 0, result_valid 0, result 0.

## Timing
- Start accepted at cycle 0 (stall_req high combinationally that cycle).
- CALC occupies cycles 1..WIDTH. DONE is at cycle WIDTH+1 (33 for WIDTH=32).
- stall_req is high for cycles 0..WIDTH: WIDTH+1 stall cycles.
- In the DONE cycle, start is still high for the same instruction. The divider does not restart, because DONE always exits to IDLE (or stays in DONE on hold).
- Back-to-back divides: the second instruction enters EX the cycle after DONE and is accepted from IDLE with no dead cycle.
- flush at cycle k during CALC:
  - Cycle k+1: IDLE, stall_req 0, result_valid 0.
  - The partial state is discarded; no result is ever presented.
- rst mid-operation behaves like flush and also clears result.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - Divide-by-zero and the signed-overflow case go IDLE -> DONE directly.
  - stall_req is high for cycle 0 only; result_valid at cycle 1.
- DIV_EARLY_OUT_EN undefined:
  - Every op takes the full WIDTH+1 latency.
  - Special-case results come from the fixup in DONE and are bit-identical.

## Structure
- Shared package `div_pkg`:
  - op encodings (DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU).
  - state encoding (S_IDLE, S_CALC, S_DONE).
  - the RISC-V special-case constants (all-ones quotient, INT_MIN).
- One combinational sub-module, `div_restore_step`, inputs {rem, quo, divisor}:
  - outputs the next {rem, quo}.
  - keeps the iteration datapath separate from the FSM for unit test.

## Test plan
- DIVU 100/7 with start held high: stall_req cycles 0..32; result_valid at cycle 33; result 14. Repeat with REMU: 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7 / -2 -> 1.
- Divisor zero, DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5:
  - with DIV_EARLY_OUT_EN, result_valid at cycle 1;
  - without it, at cycle 33.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- flush at cycle 10 of CALC -> IDLE at cycle 11, stall_req 0, result_valid never asserted. A new start at cycle 11 gives the correct result at cycle 44.
- hold high for 3 cycles in DONE -> result_valid and result stable all 3 cycles, no restart, then IDLE. rst asserted in CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the EX-stage divider.
//   - op encodings as driven by the decoder on ex_div_unit.op
//   - FSM state encoding for ex_div_unit
//   - RISC-V special-case result constants for the 32-bit datapath
package div_pkg;

    localparam int unsigned DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    localparam logic [DIV_XLEN-1:0] DIV_QUO_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [DIV_XLEN-1:0] DIV_INT_MIN      = 32'h8000_0000;

    // DIV/REM are signed (op[0] == 0); REM/REMU return the remainder (op[1] == 1).
    function automatic logic div_op_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic div_op_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one radix-2 restoring-division iteration (purely combinational).
// Ports:
//   rem      partial remainder, always < divisor for non-zero divisor
//   quo      dividend bits still to be shifted in (MSB first) / quotient bits shifted in
//   divisor  divisor magnitude
//   rem_next next partial remainder
//   quo_next next {dividend, quotient} shift register
module div_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        // shifted < 2*divisor, so a WIDTH+1 bit difference carries the borrow in its MSB.
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for the EX stage (DIV/DIVU/REM/REMU).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          EX holds a valid divide/remainder op
//   op             div_op_e encoding
//   src1, src2     dividend, divisor (forwarded operands)
//   flush          EX flush; aborts any operation, beats start and hold
//   hold           downstream stalled; keeps the result presented in DONE
//   stall_req      freeze front of pipe while the divide is being accepted/computed
//   result_valid   result available for EX/MEM capture (DONE only)
//   result         quotient or remainder, 0 when not valid
// Build option: DIV_EARLY_OUT_EN sends divide-by-zero and signed overflow straight
// from IDLE to DONE; otherwise those cases run the full iteration and are fixed up.
module ex_div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_req,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned      CntW      = $clog2(WIDTH);
    localparam logic [CntW-1:0]  LastCount = CntW'(WIDTH - 1);

    div_state_e       state_q;
    logic [CntW-1:0]  count_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             neg_quo_q, neg_rem_q, is_rem_q, div_zero_q;
    logic             result_valid_q;
    logic [WIDTH-1:0] result_q;

    logic             is_signed, src1_neg, src2_neg, in_div_zero;
    logic [WIDTH-1:0] src1_mag, src2_mag;
    logic [WIDTH-1:0] rem_next, quo_next;

    always_comb begin
        is_signed   = div_op_signed(op);
        src1_neg    = is_signed & src1[WIDTH-1];
        src2_neg    = is_signed & src2[WIDTH-1];
        // INT_MIN negates to itself, which read unsigned is the correct magnitude.
        src1_mag    = src1_neg ? (~src1 + 1'b1) : src1;
        src2_mag    = src2_neg ? (~src2 + 1'b1) : src2;
        in_div_zero = (src2 == '0);
    end

`ifdef DIV_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] IntMin = {1'b1, {(WIDTH-1){1'b0}}};

    logic             in_ovf;
    logic [WIDTH-1:0] early_res;

    always_comb begin
        in_ovf = is_signed & (src1 == IntMin) & (src2 == '1);
        if (div_op_rem(op)) begin
            early_res = in_div_zero ? src1 : '0;
        end else begin
            early_res = in_div_zero ? '1 : IntMin;
        end
    end
`endif

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Divide-by-zero leaves |src1| in the remainder naturally, so only the quotient needs
    // overriding. Signed overflow falls out of the magnitude path unchanged.
    function automatic logic [WIDTH-1:0] sign_fix(
        input logic [WIDTH-1:0] quo_mag,
        input logic [WIDTH-1:0] rem_mag,
        input logic             neg_quo,
        input logic             neg_rem,
        input logic             want_rem,
        input logic             div_zero
    );
        if (want_rem) begin
            return neg_rem ? (~rem_mag + 1'b1) : rem_mag;
        end
        if (div_zero) begin
            return '1;
        end
        return neg_quo ? (~quo_mag + 1'b1) : quo_mag;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else if (flush) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rem_q      <= '0;
                        quo_q      <= src1_mag;
                        dvs_q      <= src2_mag;
                        neg_quo_q  <= src1_neg ^ src2_neg;
                        neg_rem_q  <= src1_neg;
                        is_rem_q   <= div_op_rem(op);
                        div_zero_q <= in_div_zero;
                        count_q    <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (in_div_zero || in_ovf) begin
                            state_q        <= S_DONE;
                            result_valid_q <= 1'b1;
                            result_q       <= early_res;
                        end else begin
                            state_q <= S_CALC;
                        end
`else
                        state_q <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (count_q == LastCount) begin
                        state_q        <= S_DONE;
                        result_valid_q <= 1'b1;
                        result_q       <= sign_fix(quo_next, rem_next, neg_quo_q, neg_rem_q,
                                                   is_rem_q, div_zero_q);
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // start is still high for the finished instruction; never restart here.
                    if (!hold) begin
                        state_q        <= S_IDLE;
                        result_valid_q <= 1'b0;
                        result_q       <= '0;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    result_valid_q <= 1'b0;
                    result_q       <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_req = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
    end

    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit.
module tb_ex_div_unit;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        stall_req;
    logic        result_valid;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int LatSpecial = 1;
`else
    localparam int LatSpecial = 33;
`endif

    ex_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .src1         (src1),
        .src2         (src2),
        .flush        (flush),
        .hold         (hold),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, then sample 1 ns later.
    task automatic cyc(input logic s, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic f, input logic h);
        @(negedge clk);
        start = s;
        op    = o;
        src1  = a;
        src2  = b;
        flush = f;
        hold  = h;
        #1;
    endtask

    // Holds start high from cycle 0 until result_valid; leaves start high on return.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input logic h);
        int          lat    = -1;
        int          stalls = 0;
        logic [31:0] res    = '0;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b1, o, a, b, 1'b0, h);
            if (stall_req) stalls++;
            if (result_valid) begin
                lat = c;
                res = result;
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " stalls"}, stalls, exp_lat);
        chk({tag, " result"}, res, exp_res);
    endtask

    task automatic idle_chk(input string tag);
        cyc(1'b0, DIV_OP_DIV, '0, '0, 1'b0, 1'b0);
        chk({tag, " stall_req"}, {31'b0, stall_req}, 32'd0);
        chk({tag, " result_valid"}, {31'b0, result_valid}, 32'd0);
        chk({tag, " result"}, result, 32'd0);
    endtask

    initial begin
        int seen;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset stall_req", {31'b0, stall_req}, 32'd0);
        chk("reset result_valid", {31'b0, result_valid}, 32'd0);
        chk("reset result", result, 32'd0);

        // Unsigned, back-to-back (second op accepted straight out of DONE)
        run_op("divu 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run_op("remu 100/7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        idle_chk("after remu");

        // Signed
        run_op("div -7/2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem -7/2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("rem 7/-2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
        run_op("div 7/-2", DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);

        // Divide by zero
        run_op("div 5/0", DIV_OP_DIV, 32'd5, 32'd0, DIV_QUO_ALL_ONES, LatSpecial, 1'b0);
        run_op("rem 5/0", DIV_OP_REM, 32'd5, 32'd0, 32'd5, LatSpecial, 1'b0);
        run_op("div -5/0", DIV_OP_DIV, 32'hFFFF_FFFB, 32'd0, DIV_QUO_ALL_ONES, LatSpecial, 1'b0);
        run_op("rem -5/0", DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LatSpecial, 1'b0);
        run_op("divu max/0", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd0, DIV_QUO_ALL_ONES, LatSpecial,
               1'b0);

        // Signed overflow; the unsigned view of the same operands is an ordinary divide
        run_op("div min/-1", DIV_OP_DIV, DIV_INT_MIN, 32'hFFFF_FFFF, DIV_INT_MIN, LatSpecial,
               1'b0);
        run_op("rem min/-1", DIV_OP_REM, DIV_INT_MIN, 32'hFFFF_FFFF, 32'd0, LatSpecial, 1'b0);
        run_op("divu min/max", DIV_OP_DIVU, DIV_INT_MIN, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
        run_op("remu min/max", DIV_OP_REMU, DIV_INT_MIN, 32'hFFFF_FFFF, DIV_INT_MIN, 33, 1'b0);
        idle_chk("after specials");

        // Flush in IDLE beats start: nothing accepted
        cyc(1'b1, DIV_OP_DIVU, 32'd9, 32'd3, 1'b1, 1'b0);
        chk("idle flush stall_req", {31'b0, stall_req}, 32'd0);
        idle_chk("idle flush next");

        // Flush at cycle 10 of an op, then idle: no result ever appears
        for (int c = 0; c <= 9; c++) cyc(1'b1, DIV_OP_DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
        cyc(1'b1, DIV_OP_DIVU, 32'd1000, 32'd3, 1'b1, 1'b0);
        idle_chk("flush k+1");
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            cyc(1'b0, DIV_OP_DIVU, '0, '0, 1'b0, 1'b0);
            if (result_valid) seen++;
        end
        chk("flush no result", seen, 0);

        // Flush at cycle 10, new start at cycle 11 completes at cycle 44
        for (int c = 0; c <= 9; c++) cyc(1'b1, DIV_OP_DIV, 32'd77, 32'd5, 1'b0, 1'b0);
        cyc(1'b1, DIV_OP_DIV, 32'd77, 32'd5, 1'b1, 1'b0);
        run_op("post-flush divu", DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, 1'b0);
        idle_chk("post-flush idle");

        // Hold in DONE for 3 cycles with start still high
        run_op("hold divu", DIV_OP_DIVU, 32'd50, 32'd5, 32'd10, 33, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, DIV_OP_DIVU, 32'd50, 32'd5, 1'b0, 1'b1);
            chk("hold valid", {31'b0, result_valid}, 32'd1);
            chk("hold result", result, 32'd10);
            chk("hold stall_req", {31'b0, stall_req}, 32'd0);
        end
        cyc(1'b1, DIV_OP_DIVU, 32'd50, 32'd5, 1'b0, 1'b0);
        chk("hold release valid", {31'b0, result_valid}, 32'd1);
        chk("hold release result", result, 32'd10);
        idle_chk("after hold");

        // Reset during CALC
        for (int c = 0; c < 5; c++) cyc(1'b1, DIV_OP_REM, 32'd123, 32'd10, 1'b0, 1'b0);
        chk("calc stall_req", {31'b0, stall_req}, 32'd1);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst calc stall_req", {31'b0, stall_req}, 32'd0);
        chk("rst calc result_valid", {31'b0, result_valid}, 32'd0);
        chk("rst calc result", result, 32'd0);

        // Reset while a result is held in DONE clears it
        run_op("rst-done rem", DIV_OP_REM, 32'd123, 32'd10, 32'd3, 33, 1'b1);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst done result_valid", {31'b0, result_valid}, 32'd0);
        chk("rst done result", result, 32'd0);
        hold = 1'b0;
        idle_chk("end idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
